// File: rtl/dmem_sched_pkg.sv
// Shared types for the data-port scheduler: read FSM states and write-buffer entry layout.
package dmem_sched_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DISCARD = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Word address used for load/store ordering checks.
    function automatic logic [WORD_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/dmem_sched_store_buffer.sv
// In-order store FIFO with a per-entry word-address compare for load hazard detection.
module dmem_sched_store_buffer
    import dmem_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_push,
    input  wb_entry_t         i_entry,
    input  logic              i_pop,
    input  logic [WORD_W-1:0] i_cmp_waddr,
    output logic              o_hit,
    output logic              o_full,
    output logic              o_empty,
    output wb_entry_t         o_head
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [DEPTH-1:0] r_vld;
    wb_entry_t        r_mem [DEPTH];

    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) && (w_wr_idx == w_rd_idx);
    assign o_head   = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
        end else begin
            if (i_push) begin
                r_vld[w_wr_idx] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_vld[w_rd_idx] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset; r_vld qualifies every use.
    always_ff @(posedge CLK) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_entry;
        end
    end

    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (word_addr(r_mem[i].addr) == i_cmp_waddr)) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_sched.sv
// Data-port scheduler: issues loads, buffers and drains stores in order, and holds
// loads behind buffered stores to the same word.
module dmem_sched
    import dmem_sched_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        REQ_R_VALID,
    input  logic [31:0] REQ_R_ADDR,
    input  logic        REQ_W_VALID,
    input  logic [31:0] REQ_W_ADDR,
    input  logic [3:0]  REQ_W_STRB,
    input  logic [31:0] REQ_W_DATA,
    output logic        STALL,
    output logic        RESP_R_VALID,
    output logic [31:0] RESP_R_DATA,
    output logic        WB_EMPTY,
    output logic        DATA_RDEN,
    output logic [31:0] DATA_RIADDR,
    input  logic [31:0] DATA_ROADDR,
    input  logic        DATA_RVALID,
    input  logic [31:0] DATA_RDATA,
    output logic        DATA_WREN,
    output logic [31:0] DATA_WADDR,
    output logic [3:0]  DATA_WSTRB,
    output logic [31:0] DATA_WDATA,
    input  logic        DATA_WREADY
);

    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic [31:0]       r_addr;
    logic              r_w_taken;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic              w_hazard;
    logic              w_rd_match;
    logic              w_latch;
    logic [WORD_W-1:0] w_cmp_waddr;
    wb_entry_t         w_wr_entry;
    wb_entry_t         w_head;

    // In IDLE the live request is checked; once parked in DRAIN the latched address is.
    assign w_cmp_waddr = (r_state == ST_IDLE) ? word_addr(REQ_R_ADDR) : word_addr(r_addr);
    assign w_push      = REQ_W_VALID & ~r_w_taken & ~w_full;
    assign w_pop       = ~w_empty & DATA_WREADY;
    assign w_hazard    = w_hit | (w_push & (word_addr(REQ_W_ADDR) == w_cmp_waddr));
    assign w_rd_match  = DATA_RVALID & (DATA_ROADDR == r_addr);
    assign w_wr_entry  = '{addr: REQ_W_ADDR, strb: REQ_W_STRB, data: REQ_W_DATA};

    assign STALL = (REQ_R_VALID & ~((r_state == ST_RD_WAIT) & w_rd_match))
                 | (REQ_W_VALID & ~r_w_taken & w_full)
                 | (r_state == ST_DISCARD);

    assign WB_EMPTY    = w_empty;
    assign DATA_WREN   = ~w_empty;
    assign DATA_WADDR  = w_head.addr;
    assign DATA_WSTRB  = w_head.strb;
    assign DATA_WDATA  = w_head.data;
    assign RESP_R_DATA = RESP_R_VALID ? DATA_RDATA : '0;

    dmem_sched_store_buffer #(
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (w_push),
        .i_entry     (w_wr_entry),
        .i_pop       (w_pop),
        .i_cmp_waddr (w_cmp_waddr),
        .o_hit       (w_hit),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_addr <= REQ_R_ADDR;
            end
        end
    end

    // A store held across a stall is pushed only once.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH || !STALL) begin
            r_w_taken <= 1'b0;
        end else if (w_push) begin
            r_w_taken <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        DATA_RDEN    = 1'b0;
        DATA_RIADDR  = '0;
        RESP_R_VALID = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!FLUSH && REQ_R_VALID) begin
                    w_latch = 1'b1;
                    if (w_hazard) begin
                        w_next_state = ST_DRAIN;
                    end else begin
                        DATA_RDEN    = 1'b1;
                        DATA_RIADDR  = REQ_R_ADDR;
                        w_next_state = ST_RD_WAIT;
                    end
                end
            end
            ST_DRAIN: begin
                if (FLUSH) begin
                    w_next_state = ST_IDLE;
                end else if (!w_hazard) begin
                    DATA_RDEN    = 1'b1;
                    DATA_RIADDR  = r_addr;
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (FLUSH) begin
                    w_next_state = w_rd_match ? ST_IDLE : ST_DISCARD;
                end else if (w_rd_match) begin
                    RESP_R_VALID = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (w_rd_match) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_sched.sv
// Directed scoreboard bench for dmem_sched: expected MMU reads, writes and load responses
// are queued by the stimulus and checked by an independent monitor.
module tb_dmem_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic        REQ_R_VALID = 1'b0;
    logic [31:0] REQ_R_ADDR = '0;
    logic        REQ_W_VALID = 1'b0;
    logic [31:0] REQ_W_ADDR = '0;
    logic [3:0]  REQ_W_STRB = '0;
    logic [31:0] REQ_W_DATA = '0;
    logic        STALL;
    logic        RESP_R_VALID;
    logic [31:0] RESP_R_DATA;
    logic        WB_EMPTY;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR = '0;
    logic        DATA_RVALID = 1'b0;
    logic [31:0] DATA_RDATA = '0;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WDATA;
    logic        DATA_WREADY = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_resp_q[$];
    logic [67:0] exp_wr_q[$];

    dmem_sched #(.WB_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .REQ_R_VALID(REQ_R_VALID), .REQ_R_ADDR(REQ_R_ADDR),
        .REQ_W_VALID(REQ_W_VALID), .REQ_W_ADDR(REQ_W_ADDR),
        .REQ_W_STRB(REQ_W_STRB), .REQ_W_DATA(REQ_W_DATA),
        .STALL(STALL), .RESP_R_VALID(RESP_R_VALID), .RESP_R_DATA(RESP_R_DATA),
        .WB_EMPTY(WB_EMPTY), .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
        .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WSTRB(DATA_WSTRB),
        .DATA_WDATA(DATA_WDATA), .DATA_WREADY(DATA_WREADY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [67:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected %h expected none", nm, act);
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        REQ_W_VALID = 1'b1;
        REQ_W_ADDR  = a;
        REQ_W_STRB  = s;
        REQ_W_DATA  = d;
    endtask

    task automatic idle_inputs();
        REQ_R_VALID = 1'b0;
        REQ_W_VALID = 1'b0;
        DATA_RVALID = 1'b0;
        FLUSH       = 1'b0;
    endtask

    // Scoreboard monitor: every MMU read strobe, accepted write and load response
    // must match the next expectation queued by the stimulus.
    always @(negedge CLK) begin
        if (!RST) begin
            if (DATA_RDEN) begin
                if (exp_rd_q.size() == 0) unexpected("rd_issue", 68'(DATA_RIADDR));
                else chk("rd_issue", 68'(DATA_RIADDR), 68'(exp_rd_q.pop_front()));
            end
            if (DATA_WREN && DATA_WREADY) begin
                if (exp_wr_q.size() == 0) unexpected("wr_drain", {DATA_WADDR, DATA_WSTRB, DATA_WDATA});
                else chk("wr_drain", {DATA_WADDR, DATA_WSTRB, DATA_WDATA}, exp_wr_q.pop_front());
            end
            if (RESP_R_VALID) begin
                if (exp_resp_q.size() == 0) unexpected("resp", 68'(RESP_R_DATA));
                else chk("resp", 68'(RESP_R_DATA), 68'(exp_resp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        next_cyc(); next_cyc();
        RST = 1'b0;
        mid();
        chk("rst_stall", 68'(STALL), 68'(0));
        chk("rst_wb_empty", 68'(WB_EMPTY), 68'(1));
        chk("rst_wren", 68'(DATA_WREN), 68'(0));
        chk("rst_rden", 68'(DATA_RDEN), 68'(0));
        chk("rst_resp_v", 68'(RESP_R_VALID), 68'(0));
        chk("rst_waddr", 68'(DATA_WADDR), 68'(0));
        chk("rst_riaddr", 68'(DATA_RIADDR), 68'(0));

        // 1: plain load, response 3 cycles after issue; a stray response is ignored
        next_cyc();
        exp_rd_q.push_back(32'h100);
        exp_resp_q.push_back(32'hDEADBEEF);
        REQ_R_VALID = 1'b1; REQ_R_ADDR = 32'h100;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                DATA_RVALID = 1'b1; DATA_ROADDR = 32'h104; DATA_RDATA = 32'hBAD0BAD0;
            end else begin
                DATA_RVALID = 1'b0;
            end
            mid();
            chk("t1_stall", 68'(STALL), 68'(1));
            chk("t1_rden", 68'(DATA_RDEN), 68'(i == 0));
            next_cyc();
        end
        DATA_RVALID = 1'b1; DATA_ROADDR = 32'h100; DATA_RDATA = 32'hDEADBEEF;
        mid();
        chk("t1_stall_resp", 68'(STALL), 68'(0));
        chk("t1_resp_v", 68'(RESP_R_VALID), 68'(1));
        next_cyc();
        idle_inputs();
        mid();
        chk("t1_stall_after", 68'(STALL), 68'(0));

        // 2: load to a word held in the write buffer waits for that store to drain
        next_cyc();
        store(32'h200, 4'hF, 32'h12345678);
        exp_wr_q.push_back({32'h200, 4'hF, 32'h12345678});
        mid();
        chk("t2_push_stall", 68'(STALL), 68'(0));
        next_cyc();
        REQ_W_VALID = 1'b0;
        REQ_R_VALID = 1'b1; REQ_R_ADDR = 32'h202;
        for (int i = 0; i < 5; i++) begin
            DATA_WREADY = (i == 4);
            mid();
            chk("t2_rden_blocked", 68'(DATA_RDEN), 68'(0));
            chk("t2_stall", 68'(STALL), 68'(1));
            next_cyc();
        end
        DATA_WREADY = 1'b0;
        exp_rd_q.push_back(32'h202);
        exp_resp_q.push_back(32'hCAFEF00D);
        mid();
        chk("t2_rden_after_pop", 68'(DATA_RDEN), 68'(1));
        chk("t2_wb_empty", 68'(WB_EMPTY), 68'(1));
        next_cyc();
        DATA_RVALID = 1'b1; DATA_ROADDR = 32'h202; DATA_RDATA = 32'hCAFEF00D;
        mid();
        chk("t2_resp_v", 68'(RESP_R_VALID), 68'(1));
        next_cyc();
        idle_inputs();

        // 3: five stores into a 4-deep buffer; the fifth stalls until one slot drains
        for (int k = 0; k < 5; k++) begin
            store(32'h400 + 32'(4 * k), 4'h1, 32'(k + 1));
            exp_wr_q.push_back({32'h400 + 32'(4 * k), 4'h1, 32'(k + 1)});
            mid();
            chk("t3_stall_fill", 68'(STALL), 68'(k == 4));
            next_cyc();
        end
        mid();
        chk("t3_stall_full", 68'(STALL), 68'(1));
        next_cyc();
        DATA_WREADY = 1'b1;
        mid();
        chk("t3_stall_popcyc", 68'(STALL), 68'(1));
        next_cyc();
        DATA_WREADY = 1'b0;
        mid();
        chk("t3_stall_pushed", 68'(STALL), 68'(0));
        next_cyc();
        REQ_W_VALID = 1'b0;
        DATA_WREADY = 1'b1;
        repeat (6) next_cyc();
        DATA_WREADY = 1'b0;
        mid();
        chk("t3_wb_empty", 68'(WB_EMPTY), 68'(1));
        next_cyc();

        // 4: same-cycle load and store to one word; load issues only after the store pops
        REQ_R_VALID = 1'b1; REQ_R_ADDR = 32'h300;
        store(32'h300, 4'h3, 32'hA5A5A5A5);
        exp_wr_q.push_back({32'h300, 4'h3, 32'hA5A5A5A5});
        for (int i = 0; i < 4; i++) begin
            DATA_WREADY = (i == 3);
            mid();
            chk("t4_stall", 68'(STALL), 68'(1));
            chk("t4_rden_blocked", 68'(DATA_RDEN), 68'(0));
            next_cyc();
        end
        DATA_WREADY = 1'b0;
        exp_rd_q.push_back(32'h300);
        exp_resp_q.push_back(32'h11112222);
        mid();
        chk("t4_rden", 68'(DATA_RDEN), 68'(1));
        next_cyc();
        DATA_RVALID = 1'b1; DATA_ROADDR = 32'h300; DATA_RDATA = 32'h11112222;
        mid();
        chk("t4_stall_resp", 68'(STALL), 68'(0));
        next_cyc();
        idle_inputs();

        // 5: flush while a load is outstanding; the late response is swallowed
        store(32'h500, 4'hF, 32'h00000055);
        exp_wr_q.push_back({32'h500, 4'hF, 32'h00000055});
        next_cyc();
        REQ_W_VALID = 1'b0;
        REQ_R_VALID = 1'b1; REQ_R_ADDR = 32'h600;
        exp_rd_q.push_back(32'h600);
        next_cyc();
        REQ_R_VALID = 1'b0;
        FLUSH = 1'b1;
        next_cyc();
        FLUSH = 1'b0;
        mid();
        chk("t5_discard_stall", 68'(STALL), 68'(1));
        next_cyc();
        DATA_RVALID = 1'b1; DATA_ROADDR = 32'h600; DATA_RDATA = 32'h66666666;
        mid();
        chk("t5_resp_v", 68'(RESP_R_VALID), 68'(0));
        chk("t5_stall_swallow", 68'(STALL), 68'(1));
        next_cyc();
        DATA_RVALID = 1'b0;
        mid();
        chk("t5_stall_idle", 68'(STALL), 68'(0));
        chk("t5_wb_kept", 68'(WB_EMPTY), 68'(0));
        next_cyc();
        DATA_WREADY = 1'b1;
        next_cyc();
        DATA_WREADY = 1'b0;
        next_cyc();

        // 6: reset with two buffered stores and a load in flight
        store(32'h700, 4'hF, 32'h70);
        next_cyc();
        store(32'h704, 4'hF, 32'h74);
        next_cyc();
        REQ_W_VALID = 1'b0;
        REQ_R_VALID = 1'b1; REQ_R_ADDR = 32'h800;
        exp_rd_q.push_back(32'h800);
        next_cyc();
        REQ_R_VALID = 1'b0;
        RST = 1'b1;
        next_cyc();
        RST = 1'b0;
        DATA_RVALID = 1'b1; DATA_ROADDR = 32'h800; DATA_RDATA = 32'h88888888;
        mid();
        chk("t6_wb_empty", 68'(WB_EMPTY), 68'(1));
        chk("t6_stall", 68'(STALL), 68'(0));
        chk("t6_wren", 68'(DATA_WREN), 68'(0));
        chk("t6_rden", 68'(DATA_RDEN), 68'(0));
        chk("t6_resp_v", 68'(RESP_R_VALID), 68'(0));
        next_cyc();
        idle_inputs();
        next_cyc();

        chk("left_rd", 68'(exp_rd_q.size()), 68'(0));
        chk("left_wr", 68'(exp_wr_q.size()), 68'(0));
        chk("left_resp", 68'(exp_resp_q.size()), 68'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
